// File: rtl/pixel_readout_sequencer_if.sv
// Readout-tree and hit-stream signal bundle for pixel_readout_sequencer.
//
// Tree side : ReadCLK (strobe to tree root), valid (root has a pending hit),
//             addrOut (root address of the highest-priority pending hit).
// Hit stream: hitValid / hitReady / hitData valid-ready handshake carrying
//             {pixIdx[6:0], timeCnt[7:0]}.
//
// master: the sequencer side. slave: the tree model plus the hit consumer.
interface pixel_readout_sequencer_if;
  logic        ReadCLK;
  logic        valid;
  logic [14:0] addrOut;
  logic        hitValid;
  logic        hitReady;
  logic [14:0] hitData;

  modport master (
    output ReadCLK,
    input  valid,
    input  addrOut,
    output hitValid,
    input  hitReady,
    output hitData
  );

  modport slave (
    input  ReadCLK,
    output valid,
    output addrOut,
    input  hitValid,
    output hitReady,
    input  hitData
  );
endinterface

// File: rtl/pixel_readout_sequencer.sv
// Frame readout sequencer for a 90-pixel priority-encode readout tree.
//
// Per frame it strobes the tree root once per pending hit, decodes each root
// address into {pixIdx, timeCnt}, buffers the words in a first-word-fall-through
// FIFO and reports completion with a frameDone pulse and the hit count.
//
// Ports:
//   CLK, RST   system clock, synchronous active-high reset
//   start      one-cycle frame-read request (honoured only when idle)
//   abort      end the frame at the next safe point (after any strobe/settle)
//   bus        tree strobe/valid/address plus hit valid/ready/data stream
//   busy       high whenever the sequencer is not idle
//   frameDone  one-cycle pulse at the end of a frame
//   hitCount   hits read in the last completed frame
//   addrErr    sticky: a decoded pixel index was >= PIXS; cleared on start
module pixel_readout_sequencer #(
  parameter int unsigned PIXS     = 90,
  parameter int unsigned STRB_CYC = 2,
  parameter int unsigned SETL_CYC = 3,
  parameter int unsigned FIFO_DEP = 4,
  parameter int unsigned MAX_HITS = 90
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             start,
  input  logic                             abort,
  pixel_readout_sequencer_if.master        bus,
  output logic                             busy,
  output logic                             frameDone,
  output logic [7:0]                       hitCount,
  output logic                             addrErr
);

  localparam int unsigned AW       = $clog2(FIFO_DEP);
  localparam logic [3:0]  StrbLast = 4'(STRB_CYC - 1);
  localparam logic [3:0]  SetlLast = 4'(SETL_CYC - 1);
  localparam logic [7:0]  MaxHits  = 8'(MAX_HITS);
  localparam logic [7:0]  PixLim   = 8'(PIXS);

  typedef enum logic [2:0] {
    StIdle,
    StSample,
    StStrobe,
    StSettle,
    StDone
  } state_e;

  state_e state_q, state_d;
  logic [3:0]  tmr_q, tmr_d;
  logic [7:0]  count_q;
  logic [7:0]  hit_count_q;
  logic        addr_err_q;
  logic        abort_pend_q;
  logic        done_q;
  logic        valid_q;
  logic [14:0] addr_q;

  logic        read_clk;
  logic        push;
  logic        frame_start;
  logic        frame_end;

  // FIFO
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [14:0]  mem_q [FIFO_DEP];
  logic         fifo_empty, fifo_full, pop, wr_en;
  logic [6:0]   pix_idx;
  logic [14:0]  hit_word;

  // The fixed 2/2/2/1 tree-level radix decode collapses to plain binary, so
  // the pixel index is simply the upper seven address bits.
  assign pix_idx  = {addr_q[14:13], addr_q[12:11], addr_q[10:9], addr_q[8]};
  assign hit_word = {pix_idx, addr_q[7:0]};

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !fifo_empty && bus.hitReady;
  assign wr_en      = push && (!fifo_full || pop);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StSample;
      end
      StSample: begin
        if (abort || abort_pend_q || (count_q == MaxHits)) begin
          state_d = StDone;
        end else if (!valid_q) begin
          state_d = StDone;
        end else if (!fifo_full) begin
          state_d = StStrobe;
        end
      end
      StStrobe: begin
        if (tmr_q == StrbLast) state_d = StSettle;
      end
      StSettle: begin
        if (tmr_q == SetlLast) state_d = StSample;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Dwell timer restarts on every state change.
    tmr_d = (state_d == state_q) ? tmr_q + 4'd1 : 4'd0;
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    read_clk    = 1'b0;
    push        = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    unique case (state_q)
      StIdle: begin
        frame_start = start;
      end
      StStrobe: begin
        read_clk = 1'b1;
        push     = (tmr_q == 4'd0);
      end
      StDone: begin
        frame_end = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Reset drops the strobe in the same cycle rather than one edge later.
  assign bus.ReadCLK = read_clk && !RST;
  assign busy        = (state_q != StIdle);
  assign frameDone   = done_q;
  assign hitCount    = hit_count_q;
  assign addrErr     = addr_err_q;

  // ---------------------------------------------------------------------------
  // Input stage, frame counters and status
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q      <= 1'b0;
      addr_q       <= '0;
      count_q      <= '0;
      hit_count_q  <= '0;
      addr_err_q   <= 1'b0;
      abort_pend_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      valid_q <= bus.valid;
      addr_q  <= bus.addrOut;
      done_q  <= frame_end;

      if (frame_start) begin
        count_q      <= '0;
        addr_err_q   <= 1'b0;
        abort_pend_q <= 1'b0;
      end else begin
        if (push) begin
          if (count_q != MaxHits) count_q <= count_q + 8'd1;
          // Out-of-range words are still pushed; the flag lets the frame
          // logic discard the frame if it chooses.
          if ({1'b0, pix_idx} >= PixLim) addr_err_q <= 1'b1;
        end
        // An abort during a strobe or settle is held until SAMPLE so the
        // current hit always completes its full strobe and tree settle.
        if (abort && ((state_q == StStrobe) || (state_q == StSettle))) begin
          abort_pend_q <= 1'b1;
        end
        if (frame_end) abort_pend_q <= 1'b0;
      end

      if (frame_end) hit_count_q <= count_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Hit FIFO (first-word-fall-through, drains across frames)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= hit_word;
  end

  assign bus.hitValid = !fifo_empty;
  assign bus.hitData  = fifo_empty ? 15'd0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule
